// File: rtl/fwnoc_pkg.sv
// fwnoc_pkg: header field positions, size-code decode and FSM encodings for the router.
package fwnoc_pkg;
    localparam int DAT_W = 32;
    localparam int DST_X_HI = 31;
    localparam int DST_X_LO = 30;
    localparam int DST_Y_HI = 29;
    localparam int DST_Y_LO = 28;
    localparam int SZ_HI = 3;
    localparam int SZ_LO = 0;
    typedef enum logic {ST_IDLE, ST_FWD} state_t;
    // Codes 6..15 decode to a header-only packet.
    function automatic logic [4:0] fwnoc_sz_decode(input logic [3:0] code);
        return (code == 4'd0 || code > 4'd5) ? 5'd0 : 5'd1 << (code - 4'd1);
    endfunction
endpackage

// File: rtl/fwnoc_rr_arbiter.sv
// fwnoc_rr_arbiter: combinational round-robin pick, searching upward from last+1.
module fwnoc_rr_arbiter #(
    parameter int N = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          any
);
    // Scan from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                idx = IW'((int'(last) + i) % N);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fwnoc_router_egress_arb.sv
// fwnoc_router_egress_arb: round-robin packet arbiter for one router output port.
module fwnoc_router_egress_arb
    import fwnoc_pkg::*;
#(
    parameter int N_INPUTS = 5,
    parameter int DAT_W = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_INPUTS-1:0]       i_valid,
    output logic [N_INPUTS-1:0]       i_ready,
    input  logic [N_INPUTS*DAT_W-1:0] i_dat,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [DAT_W-1:0]          o_dat
);
    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    state_t state, state_d;
    logic [IW-1:0] grant, last, arb_idx;
    logic arb_any, first, xfer, done;
    logic [4:0] rem, hdr_sz;
    fwnoc_rr_arbiter #(.N(N_INPUTS)) u_arb (
        .req(i_valid),
        .last(last),
        .idx(arb_idx),
        .any(arb_any)
    );
    always_comb begin
        o_dat = i_dat[DAT_W*grant +: DAT_W];
        o_valid = state == ST_FWD && i_valid[grant];
        i_ready = state == ST_FWD ? N_INPUTS'(o_ready) << grant : '0;
        xfer = o_valid && o_ready;
        hdr_sz = fwnoc_sz_decode(o_dat[SZ_HI:SZ_LO]);
        done = xfer && (first ? hdr_sz == 5'd0 : rem == 5'd1);
        state_d = state == ST_IDLE ? (arb_any ? ST_FWD : ST_IDLE) : (done ? ST_IDLE : ST_FWD);
    end
    // Grant is captured only in IDLE, so it is held for the whole packet.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            grant <= '0;
            first <= 1'b0;
            rem <= '0;
            last <= IW'(N_INPUTS - 1);
        end else begin
            state <= state_d;
            if (state == ST_IDLE && arb_any) begin
                grant <= arb_idx;
                first <= 1'b1;
            end
            if (xfer) begin
                first <= 1'b0;
                rem <= first ? hdr_sz : rem - 5'd1;
            end
            if (done) last <= grant;
        end
    end
endmodule

// File: tb/tb_fwnoc_router_egress_arb.sv
// tb_fwnoc_router_egress_arb: directed checks of arbitration, packet framing, stalls and reset.
module tb_fwnoc_router_egress_arb;
    import fwnoc_pkg::*;
    logic clock = 1'b0;
    logic reset;
    logic [4:0] i_valid, i_ready;
    logic [159:0] i_dat;
    logic o_valid, o_ready;
    logic [31:0] o_dat;
    logic [31:0] src [5][$];
    logic [31:0] outlog [$];
    int gl [$];
    logic [4:0] gate;
    logic s_ov;
    logic [4:0] s_ir, s_rem;
    logic [31:0] s_od;
    int total = 0, passed = 0;
    fwnoc_router_egress_arb #(.N_INPUTS(5), .DAT_W(32)) dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
        .i_dat(i_dat), .o_valid(o_valid), .o_ready(o_ready), .o_dat(o_dat)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else passed++;
    endtask
    task automatic drive();
        for (int k = 0; k < 5; k++) begin
            i_valid[k] = gate[k] && src[k].size() != 0;
            i_dat[32*k +: 32] = src[k].size() != 0 ? src[k][0] : 32'h0;
        end
    endtask
    // Snapshot outputs mid-cycle, then pop accepted words after the edge.
    task automatic tick();
        logic [4:0] hs;
        @(negedge clock);
        hs = i_valid & i_ready;
        s_ov = o_valid;
        s_ir = i_ready;
        s_od = o_dat;
        s_rem = dut.rem;
        if (o_valid && o_ready) begin
            outlog.push_back(o_dat);
            for (int k = 0; k < 5; k++) if (i_ready[k]) gl.push_back(k);
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 5; k++) if (hs[k]) void'(src[k].pop_front());
        drive();
    endtask
    initial begin
        logic [31:0] exp3 [8];
        logic [31:0] exp4 [5];
        int gexp [8];
        logic [11:0] pat;
        logic [4:0] rdy;
        logic [4:0] rexp [5];
        reset = 1'b1;
        o_ready = 1'b1;
        gate = '0;
        drive();
        @(posedge clock);
        #1;
        tick();
        check("rst_out", {s_ov, s_ir}, 6'h0);
        check("rst_state", 64'(dut.state), 64'(ST_IDLE));
        check("rst_last", 64'(dut.last), 64'd4);
        reset = 1'b0;
        // 1: header-only packet from requester 2
        src[2].push_back(32'h4000_0000);
        gate = 5'b00100;
        drive();
        tick();
        check("t1_idle", {s_ov, s_ir}, 6'h0);
        tick();
        check("t1_beat", {s_ov, s_ir, s_od}, {1'b1, 5'b00100, 32'h4000_0000});
        tick();
        check("t1_after", {s_ov, s_ir}, 6'h0);
        // 2: full-size packet from requester 0
        src[0].push_back(32'h0000_0005);
        for (int i = 0; i < 16; i++) src[0].push_back(32'h100 + i);
        gate = 5'b00001;
        drive();
        tick();
        check("t2_idle", s_ov, 1'b0);
        for (int i = 0; i < 17; i++) begin
            tick();
            check("t2_beat", {s_ov, s_ir, s_od}, {1'b1, 5'b00001, i == 0 ? 32'h5 : 32'h100 + i - 1});
        end
        // 3: fairness between requesters 1 and 3
        outlog.delete();
        gl.delete();
        for (int p = 0; p < 2; p++) begin
            src[1].push_back(32'h1100_0001);
            src[1].push_back(32'hA1);
            src[3].push_back(32'h3300_0001);
            src[3].push_back(32'hB3);
        end
        gate = 5'b01010;
        drive();
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            pat[i] = s_ov;
        end
        exp3 = '{32'h1100_0001, 32'hA1, 32'h3300_0001, 32'hB3, 32'h1100_0001, 32'hA1, 32'h3300_0001, 32'hB3};
        gexp = '{1, 1, 3, 3, 1, 1, 3, 3};
        check("t3_bubbles", pat, 12'b110_110_110_110);
        check("t3_nbeats", outlog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("t3_dat", outlog[i], exp3[i]);
            check("t3_grant", gl[i], gexp[i]);
        end
        // 4: backpressure on a code-2 packet from requester 2
        outlog.delete();
        src[2].push_back(32'h8000_0002);
        src[2].push_back(32'hC0);
        src[2].push_back(32'hC1);
        gate = 5'b00100;
        drive();
        tick();
        check("t4_idle", s_ov, 1'b0);
        rdy = 5'b10101;
        exp4 = '{32'h8000_0002, 32'hC0, 32'hC0, 32'hC1, 32'hC1};
        rexp = '{5'd0, 5'd2, 5'd2, 5'd1, 5'd1};
        for (int i = 0; i < 5; i++) begin
            o_ready = rdy[i];
            tick();
            check("t4_beat", {s_ov, s_ir, s_od}, {1'b1, rdy[i] ? 5'b00100 : 5'b0, exp4[i]});
            check("t4_rem", s_rem, rexp[i]);
        end
        o_ready = 1'b1;
        tick();
        check("t4_done", {s_ov, s_rem}, 6'h0);
        check("t4_nbeats", outlog.size(), 3);
        // 5: granted requester 3 gaps while requester 4 waits
        src[3].push_back(32'h3000_0002);
        src[3].push_back(32'hD0);
        src[3].push_back(32'hD1);
        src[4].push_back(32'hF000_0000);
        gate = 5'b11000;
        drive();
        tick();
        check("t5_idle", s_ov, 1'b0);
        tick();
        check("t5_hdr", {s_ov, s_ir, s_od}, {1'b1, 5'b01000, 32'h3000_0002});
        gate = 5'b10000;
        drive();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_gap", {s_ov, s_ir}, {1'b0, 5'b01000});
        end
        gate = 5'b11000;
        drive();
        tick();
        check("t5_p0", {s_ov, s_ir, s_od}, {1'b1, 5'b01000, 32'hD0});
        tick();
        check("t5_p1", {s_ov, s_ir, s_od}, {1'b1, 5'b01000, 32'hD1});
        tick();
        check("t5_idle2", {s_ov, s_ir}, 6'h0);
        tick();
        check("t5_req4", {s_ov, s_ir, s_od}, {1'b1, 5'b10000, 32'hF000_0000});
        // 6: reset on the third beat of a code-4 packet, then an illegal code
        src[1].push_back(32'h1000_0004);
        for (int i = 0; i < 8; i++) src[1].push_back(32'hE0 + i);
        gate = 5'b00010;
        drive();
        tick();
        tick();
        check("t6_hdr", {s_ov, s_ir, s_od}, {1'b1, 5'b00010, 32'h1000_0004});
        tick();
        reset = 1'b1;
        tick();
        check("t6_beat3", {s_ov, s_od}, {1'b1, 32'hE1});
        reset = 1'b0;
        gate = '0;
        src[1].delete();
        drive();
        tick();
        check("t6_rst_out", {s_ov, s_ir}, 6'h0);
        check("t6_rst_state", 64'(dut.state), 64'(ST_IDLE));
        check("t6_rst_regs", {dut.grant, dut.first, dut.rem, dut.last}, {3'd0, 1'b0, 5'd0, 3'd4});
        src[0].push_back(32'h0000_0007);
        gate = 5'b00001;
        drive();
        tick();
        check("t6_idle", s_ov, 1'b0);
        tick();
        check("t6_code7", {s_ov, s_ir, s_od}, {1'b1, 5'b00001, 32'h7});
        tick();
        check("t6_after", {s_ov, s_ir}, 6'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
